event_scheduler: RTL and testbench
==================================

EVENT_SCHEDULER -- requirements
Module: event_scheduler

Interface
REQ-001 Parameter NUM_CH, 4: number of event channels; fixed at 4 in this revision.
REQ-002 Parameter CNT_W, 8: width of the run counter and of the match values.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle run request.
REQ-006 abort  input  1  single-cycle run cancel.
REQ-007 cfg_we  input  1  configuration write strobe.
REQ-008 cfg_ch  input  2  channel selected by cfg_we.
REQ-009 cfg_match  input  CNT_W  count value at which the selected channel fires.
REQ-010 count  output  CNT_W  current run count.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 done  output  1  single-cycle pulse when a run completes normally.
REQ-013 ev_valid  output  1  an event is being presented.
REQ-014 ev_id  output  2  channel number of the presented event.
REQ-015 ev_ready  input  1  consumer accepts the event when ev_valid and ev_ready are both high.

Function
REQ-016 Per channel: registered match value, armed bit and pending bit; FSM states IDLE, RUN and DRAIN.
REQ-017 cfg_we in IDLE: writes cfg_match to channel cfg_ch and sets its armed bit; ignored in RUN and DRAIN.
REQ-018 start in IDLE: next edge -> RUN, count=1; start ignored while busy.
REQ-019 RUN: count increments by 1 every cycle.
REQ-020 RUN, armed channel with match==count: at the same edge, pending set and armed cleared; multiple simultaneous matches all pend.
REQ-021 match value 0 never fires; that channel stays armed until the run ends, then is cleared.
REQ-022 RUN -> DRAIN at the edge where count==2^CNT_W-1 (no wrap) or where no armed channel remains after the REQ-020 update; remaining armed bits are cleared on entry to DRAIN.
REQ-023 start with no channel armed: RUN for exactly one cycle (count=1), then DRAIN, then done.
REQ-024 Output stage: when ev_valid is low or the current event handshakes, grant the next pending channel round-robin starting after the last granted channel (initial pointer 0); ev_valid/ev_id register at that edge and the granted pending bit clears.
REQ-025 Latency: match at count k in cycle t -> ev_valid high in cycle t+2 if the output stage is free.
REQ-026 ev_valid and ev_id hold stable until the handshake; back-to-back events are permitted (one per cycle while ev_ready stays high).
REQ-027 DRAIN -> IDLE when no bit is pending and ev_valid is low; done pulses high for exactly the first IDLE cycle; count returns to 0.
REQ-028 abort in RUN or DRAIN: next edge -> IDLE; pending, armed and ev_valid cleared; count=0; no done pulse; abort in IDLE has no effect.
REQ-029 abort and start in the same cycle: abort wins.

Reset
REQ-030 rst: state=IDLE; count=0; busy, done and ev_valid = 0; ev_id=0; all match values, armed bits and pending bits = 0; round-robin pointer=0.
REQ-031 rst takes priority over every other input, including mid-run and mid-handshake.

Configuration
REQ-032 Macro EVENT_SCHEDULER_STAMP_EN defined: adds output ev_stamp[CNT_W-1:0]; each channel captures count at its matching edge; ev_stamp presents the captured value with ev_id under the same hold rules; reset value 0.
REQ-033 EVENT_SCHEDULER_STAMP_EN undefined: no ev_stamp port and no stamp registers; all other behaviour is identical.

Verification
REQ-034 Arm ch2 with match=25, start, ev_ready=1 -> one event with ev_id=2, ev_valid two cycles after count==25; done follows; count back to 0.
REQ-035 Arm ch0..ch3 all with match=5, ev_ready=1 -> ev_id sequence 0,1,2,3 on consecutive cycles; exactly one done.
REQ-036 Arm ch1 with match=3, hold ev_ready=0 for 10 cycles -> ev_valid and ev_id=1 held stable; busy stays high; done only after ev_ready rises.
REQ-037 Arm ch0 with match=0 and ch1 with match=255 (CNT_W=8) -> ch1 fires at count 255; ch0 never fires; no count wrap.
REQ-038 Arm ch3 with match=40, abort at count 20 -> no event, no done, IDLE next cycle; rst asserted mid-run -> all outputs return to reset values.
REQ-039 With EVENT_SCHEDULER_STAMP_EN defined, run REQ-035 -> ev_stamp=5 on all four events.

Source files
------------

// File: rtl/event_scheduler.sv
// event_scheduler: a run counter with NUM_CH match channels. Armed channels
// fire when the count reaches their match value. Fired channels queue as
// pending events, which a round-robin output stage presents through a
// valid/ready handshake.
//
// Optional feature macro: EVENT_SCHEDULER_STAMP_EN
//   Adds the ev_stamp output, which carries the count captured at each
//   channel's match.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request (acted on in IDLE only)
//   abort      in   run cancel (acted on in RUN/DRAIN; beats start)
//   cfg_we     in   configuration write strobe (IDLE only)
//   cfg_ch     in   channel selected by cfg_we
//   cfg_match  in   count value at which the selected channel fires
//   count      out  current run count
//   busy       out  high in RUN or DRAIN
//   done       out  one-cycle pulse on normal run completion
//   ev_valid   out  event presented
//   ev_id      out  channel of the presented event
//   ev_ready   in   consumer accepts when ev_valid && ev_ready
//   ev_stamp   out  (STAMP_EN only) count captured at the event's match
module event_scheduler #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_ch,
   input  logic [CNT_W-1:0] cfg_match,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             ev_valid,
   output logic [1:0]       ev_id,
   input  logic             ev_ready
`ifdef EVENT_SCHEDULER_STAMP_EN
   ,
   output logic [CNT_W-1:0] ev_stamp
`endif
);

   localparam int unsigned ID_W = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    ev_valid_q, ev_valid_d;
   logic [ID_W-1:0]         ev_id_q, ev_id_d;
   logic [CNT_W-1:0]        match_q [NUM_CH];
   logic [CNT_W-1:0]        match_d [NUM_CH];
   logic [NUM_CH-1:0]       armed_q, armed_d;
   logic [NUM_CH-1:0]       pending_q, pending_d;
   logic [ID_W-1:0]         rr_q, rr_d;

   logic [NUM_CH-1:0]       hit_c;
   logic                    grant_vld_c;
   logic [ID_W-1:0]         grant_id_c;
   logic [ID_W-1:0]         scan_idx_c;

`ifdef EVENT_SCHEDULER_STAMP_EN
   logic [CNT_W-1:0]        stamp_q [NUM_CH];
   logic [CNT_W-1:0]        stamp_d [NUM_CH];
   logic [CNT_W-1:0]        ev_stamp_q, ev_stamp_d;
`endif

   // Channels matching the current count; a zero match value never fires.
   always_comb begin
      hit_c = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         hit_c[i] = (state_q == S_RUN) && armed_q[i] &&
                    (match_q[i] != '0) && (match_q[i] == count_q);
      end
   end

   // Round-robin pick: search starts at rr_q, the channel after the last grant.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_id_c  = '0;
      scan_idx_c  = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         scan_idx_c = ID_W'((32'(rr_q) + k) % NUM_CH);
         if (!grant_vld_c && pending_q[scan_idx_c]) begin
            grant_vld_c = 1'b1;
            grant_id_c  = scan_idx_c;
         end
      end
   end

   // Next-state logic: FSM, channel bookkeeping and output stage.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      ev_valid_d = ev_valid_q;
      ev_id_d    = ev_id_q;
      match_d    = match_q;
      armed_d    = armed_q;
      pending_d  = pending_q | hit_c;
      rr_d       = rr_q;
`ifdef EVENT_SCHEDULER_STAMP_EN
      stamp_d    = stamp_q;
      ev_stamp_d = ev_stamp_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (hit_c[i]) stamp_d[i] = count_q;
      end
`endif

      // Output stage loads when empty or when the current event is taken.
      if (!ev_valid_q || ev_ready) begin
         ev_valid_d = grant_vld_c;
         if (grant_vld_c) begin
            ev_id_d               = grant_id_c;
            pending_d[grant_id_c] = 1'b0;
            rr_d                  = grant_id_c + ID_W'(1);
`ifdef EVENT_SCHEDULER_STAMP_EN
            ev_stamp_d            = stamp_q[grant_id_c];
`endif
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (cfg_we) begin
               match_d[cfg_ch] = cfg_match;
               armed_d[cfg_ch] = 1'b1;
            end
            if (start && !abort) begin
               state_d = S_RUN;
               count_d = CNT_W'(1);
            end
         end
         S_RUN: begin
            armed_d = armed_q & ~hit_c;
            // Leave at the top count (no wrap) or once nothing is left armed.
            if ((count_q == CNT_MAX) || (armed_d == '0)) begin
               state_d = S_DRAIN;
               armed_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if ((pending_q == '0) && !ev_valid_q) begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);

      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         count_d    = '0;
         armed_d    = '0;
         pending_d  = '0;
         ev_valid_d = 1'b0;
         done_d     = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
         armed_q    <= '0;
         pending_q  <= '0;
         rr_q       <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) match_q[i] <= '0;
`ifdef EVENT_SCHEDULER_STAMP_EN
         for (int unsigned i = 0; i < NUM_CH; i++) stamp_q[i] <= '0;
         ev_stamp_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q    <= ev_id_d;
         armed_q    <= armed_d;
         pending_q  <= pending_d;
         rr_q       <= rr_d;
         match_q    <= match_d;
`ifdef EVENT_SCHEDULER_STAMP_EN
         stamp_q    <= stamp_d;
         ev_stamp_q <= ev_stamp_d;
`endif
      end
   end

   assign count    = count_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ev_valid = ev_valid_q;
   assign ev_id    = ev_id_q;
`ifdef EVENT_SCHEDULER_STAMP_EN
   assign ev_stamp = ev_stamp_q;
`endif

endmodule

// File: tb/tb_event_scheduler.sv
// Bench for event_scheduler: directed vector table, hand-written corner
// sequences, and randomized runs checked against a run-level model.
module tb_event_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, abort, cfg_we, ev_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_match;
   logic [7:0] count;
   logic       busy, done, ev_valid;
   logic [1:0] ev_id;
`ifdef EVENT_SCHEDULER_STAMP_EN
   logic [7:0] ev_stamp;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   event_scheduler #(.NUM_CH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_match(cfg_match),
      .count(count), .busy(busy), .done(done),
      .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready)
`ifdef EVENT_SCHEDULER_STAMP_EN
      , .ev_stamp(ev_stamp)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      cfg_ch = '0; cfg_match = '0; ev_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic arm(input int ch, input int m);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_match = 8'(m);
      tick();
      cfg_we = 1'b0;
   endtask

   // Leaves the bench in run cycle 1 (count should read 1).
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   typedef struct packed {
      logic [3:0]      mask;
      logic [3:0][7:0] m;
      logic [2:0]      n_ev;
      logic [3:0][1:0] ids;
      logic [3:0][8:0] cyc;
      logic [8:0]      done_cyc;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int got_id [8];
      int got_cyc [8];
      int gn, done_at, ev_seen;
      int m [4];
      logic [3:0] expect_set;
      int run_end;
      logic prev_valid, prev_ready;
      logic [1:0] prev_id;
      logic done_seen;

      // ---- vector table (ev_ready held high; cycle 1 = first RUN cycle) ----
      for (int i = 0; i < 6; i++) vecs[i] = '0;
      vecs[0].mask = 4'b0100; vecs[0].m[2] = 8'd25; vecs[0].n_ev = 3'd1;
      vecs[0].ids[0] = 2'd2; vecs[0].cyc[0] = 9'd27; vecs[0].done_cyc = 9'd29;
      vecs[1].mask = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         vecs[1].m[i] = 8'd5; vecs[1].ids[i] = 2'(i); vecs[1].cyc[i] = 9'(7 + i);
      end
      vecs[1].n_ev = 3'd4; vecs[1].done_cyc = 9'd12;
      vecs[2].mask = 4'b0000; vecs[2].n_ev = 3'd0; vecs[2].done_cyc = 9'd3;
      vecs[3].mask = 4'b1010; vecs[3].m[1] = 8'd3; vecs[3].m[3] = 8'd3; vecs[3].n_ev = 3'd2;
      vecs[3].ids[0] = 2'd1; vecs[3].cyc[0] = 9'd5;
      vecs[3].ids[1] = 2'd3; vecs[3].cyc[1] = 9'd6; vecs[3].done_cyc = 9'd8;
      vecs[4].mask = 4'b1011; vecs[4].m[0] = 8'd10; vecs[4].m[1] = 8'd4; vecs[4].m[3] = 8'd10;
      vecs[4].n_ev = 3'd3;
      vecs[4].ids[0] = 2'd1; vecs[4].cyc[0] = 9'd6;
      vecs[4].ids[1] = 2'd3; vecs[4].cyc[1] = 9'd12;
      vecs[4].ids[2] = 2'd0; vecs[4].cyc[2] = 9'd13; vecs[4].done_cyc = 9'd15;
      vecs[5].mask = 4'b0011; vecs[5].m[0] = 8'd1; vecs[5].m[1] = 8'd2; vecs[5].n_ev = 3'd2;
      vecs[5].ids[0] = 2'd0; vecs[5].cyc[0] = 9'd3;
      vecs[5].ids[1] = 2'd1; vecs[5].cyc[1] = 9'd4; vecs[5].done_cyc = 9'd6;

      // ---- reset state ----
      do_reset();
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_id", ev_id, 0);
`ifdef EVENT_SCHEDULER_STAMP_EN
      check("rst_stamp", ev_stamp, 0);
`endif

      // ---- table-driven runs ----
      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int ch = 0; ch < 4; ch++)
            if (vecs[v].mask[ch]) arm(ch, int'(vecs[v].m[ch]));
         for (int k = 0; k < 8; k++) begin got_id[k] = -1; got_cyc[k] = -1; end
         gn = 0; done_at = -1;
         pulse_start();
         check($sformatf("v%0d_count1", v), count, 1);
         for (int c = 1; c <= 400; c++) begin
            if (ev_valid && ev_ready) begin
               if (gn < 8) begin got_id[gn] = int'(ev_id); got_cyc[gn] = c; end
               gn++;
`ifdef EVENT_SCHEDULER_STAMP_EN
               check($sformatf("v%0d_stamp", v), ev_stamp, vecs[v].m[ev_id]);
`endif
            end
            if (done) begin done_at = c; break; end
            tick();
         end
         check($sformatf("v%0d_nev", v), gn, vecs[v].n_ev);
         for (int k = 0; k < 4; k++) begin
            if (k < int'(vecs[v].n_ev)) begin
               check($sformatf("v%0d_id%0d", v, k), got_id[k], vecs[v].ids[k]);
               check($sformatf("v%0d_cyc%0d", v, k), got_cyc[k], vecs[v].cyc[k]);
            end
         end
         check($sformatf("v%0d_done_cyc", v), done_at, vecs[v].done_cyc);
         check($sformatf("v%0d_end_count", v), count, 0);
         check($sformatf("v%0d_end_busy", v), busy, 0);
         tick();
         check($sformatf("v%0d_done_pulse", v), done, 0);
      end

      // ---- backpressure: ch1 match 3, ev_ready low for 10 cycles ----
      do_reset();
      arm(1, 3);
      ev_ready = 1'b0;
      pulse_start();
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", ev_valid, 1);
         check("bp_id", ev_id, 1);
         check("bp_busy", busy, 1);
         check("bp_done", done, 0);
         tick();
      end
      ev_ready = 1'b1;
      check("bp_valid_last", ev_valid, 1);
      tick();
      check("bp_valid_off", ev_valid, 0);
      check("bp_no_early_done", done, 0);
      tick();
      check("bp_done_after", done, 1);

      // ---- match 0 never fires, match 255 fires with no wrap ----
      do_reset();
      arm(0, 0);
      arm(1, 255);
      pulse_start();
      ev_seen = 0;
      for (int c = 1; c < 255; c++) begin
         if (ev_valid || done) ev_seen++;
         tick();
      end
      check("m255_no_early_ev", ev_seen, 0);
      check("m255_count255", count, 255);
      tick();
      check("m255_nowrap", count, 255);
      check("m255_busy", busy, 1);
      tick();
      check("m255_valid", ev_valid, 1);
      check("m255_id", ev_id, 1);
      tick();
      check("m255_valid_off", ev_valid, 0);
      tick();
      check("m255_done", done, 1);
      check("m255_count0", count, 0);
      // zero-match arming must not survive into the next run
      pulse_start();
      tick(); tick();
      check("m0_cleared_done", done, 1);

      // ---- abort mid-run, start and cfg ignored while busy ----
      do_reset();
      arm(3, 40);
      pulse_start();
      ev_seen = 0;
      for (int c = 1; c < 20; c++) begin
         if (c == 5) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_match = 8'd8; end
         else cfg_we = 1'b0;
         start = (c == 10);
         if (c == 11) check("busy_start_ignored", count, 11);
         if (ev_valid || done) ev_seen++;
         tick();
      end
      cfg_we = 1'b0; start = 1'b0;
      check("abort_at_count", count, 20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_count", count, 0);
      check("abort_done", done, 0);
      check("abort_valid", ev_valid, 0);
      for (int c = 0; c < 50; c++) begin
         if (ev_valid || done || busy) ev_seen++;
         tick();
      end
      check("abort_quiet", ev_seen, 0);

      // ---- abort and start together in IDLE: abort wins ----
      arm(0, 2);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", busy, 0);
      pulse_start();
      check("restart_busy", busy, 1);
      tick(); tick(); tick();
      check("restart_valid", ev_valid, 1);
      check("restart_id", ev_id, 0);
      tick(); tick();
      check("restart_done", done, 1);

      // ---- reset mid-handshake ----
      arm(1, 3);
      ev_ready = 1'b0;
      pulse_start();
      repeat (4) tick();
      check("rsths_valid", ev_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rsths_count", count, 0);
      check("rsths_busy", busy, 0);
      check("rsths_done", done, 0);
      check("rsths_valid_off", ev_valid, 0);
      check("rsths_id", ev_id, 0);
      tick();
      check("rsths_still_idle", ev_valid | busy, 0);
      ev_ready = 1'b1;
      pulse_start();
      tick(); tick();
      check("rsths_empty_run_done", done, 1);

      // ---- randomized runs against a run-level model ----
      do_reset();
      for (int r = 0; r < 40; r++) begin
         expect_set = '0;
         for (int ch = 0; ch < 4; ch++) m[ch] = -1;
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 1) == 1) begin
               m[ch] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 60));
               arm(ch, m[ch]);
               if (m[ch] != 0) expect_set[ch] = 1'b1;
            end
         end
         // Run length: a zero-match channel keeps the run alive to the top.
         run_end = 1;
         for (int ch = 0; ch < 4; ch++) begin
            if (m[ch] == 0) run_end = 255;
            else if (m[ch] > run_end && run_end != 255) run_end = m[ch];
         end
         pulse_start();
         prev_valid = 1'b0; prev_ready = 1'b0; prev_id = '0; done_seen = 1'b0;
         for (int c = 1; c <= 600; c++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            if (c <= run_end) begin
               check("rnd_count", count, c);
               check("rnd_busy", busy, 1);
            end
            if (prev_valid && !prev_ready) begin
               check("rnd_hold_valid", ev_valid, 1);
               check("rnd_hold_id", ev_id, prev_id);
            end
            if (ev_valid && ev_ready) begin
               check("rnd_id_expected", expect_set[ev_id], 1);
               check("rnd_latency", (c >= m[ev_id] + 2), 1);
`ifdef EVENT_SCHEDULER_STAMP_EN
               check("rnd_stamp", ev_stamp, m[ev_id]);
`endif
               expect_set[ev_id] = 1'b0;
            end
            if (done) begin
               done_seen = 1'b1;
               check("rnd_done_count", count, 0);
               check("rnd_done_valid", ev_valid, 0);
               break;
            end
            prev_valid = ev_valid; prev_ready = ev_ready; prev_id = ev_id;
            tick();
         end
         check("rnd_done_seen", done_seen, 1);
         check("rnd_all_fired", expect_set, 0);
         ev_ready = 1'b1;
         if (!done_seen) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
